nvm_spike_counter_bank: RTL
===========================

Name: nvm_spike_counter_bank

Overview:
Parametrised Wishbone-readable spike accumulator for the SNN gesture core.
- Each output neuron gets a saturating spike counter, incremented from a per-timestep spike vector driven by the neuron array.
- The host reads packed counters, controls counting and clear, and monitors saturation/timestep status over a Wishbone slave port.
- Generalises the fixed 64-neuron, 4-bit spike store to N neurons, configurable counter width, and accumulate-on-chip behaviour.

Parameters:
- N_NEURONS, 64, number of neuron counters.
- CNT_W, 4, counter width in bits; must divide 32.
- TS_W, 16, timestep counter width; must be ≤ 16.
- Derived: CPW = 32/CNT_W counters per word; N_WORDS = ceil(N_NEURONS/CPW).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle valid.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  4  byte-lane selects.
- wbs_adr_i  in  32  byte address; word index = wbs_adr_i[2+:$clog2(N_WORDS+2)].
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- spike_valid_i  in  1  one-cycle pulse: spike_vec_i is valid for one timestep.
- spike_vec_i  in  N_NEURONS  bit n = neuron n fired this timestep.

Behaviour:
Clock and reset
- Single clock wb_clk_i. Reset wb_rst_i is synchronous, active-high.
- On reset: wbs_ack_o=0, wbs_dat_o=0, all counters=0, count_en=0, sat_sticky=0, ts_cnt=0.

Address map (word index)
- 0 CTRL:
  - bit0 count_en, R/W.
  - bit1 clear, write-1 pulse; reads as 0.
- 1 STATUS:
  - bit0 sat_sticky, write-1-to-clear.
  - [31:16] ts_cnt, read-only, zero-extended.
- 2..N_WORDS+1 CNT[k]: counter k*CPW+i at bits [i*CNT_W +: CNT_W]. Bits for neurons ≥ N_NEURONS read 0.
- Other indices: read 0, writes ignored, still acked.

Wishbone handshake (2-state FSM)
- IDLE: cyc&stb → ACK. Read/write is performed on this edge.
- ACK: wbs_ack_o=1 for exactly one cycle, with wbs_dat_o valid → IDLE.
- wbs_dat_o=0 whenever ack is 0.
- A strobe held through ACK is not re-accepted until IDLE, so a held request is acked every other cycle.
- Dropping cyc/stb during ACK does not cancel the ack.
- Writes: CTRL/STATUS honour lane 0 only. CNT writes (test preload) update only counters fully contained in selected byte lanes; for CNT_W > 8, all covering lanes must be set.

Accumulation
- On spike_valid_i with count_en=1:
  - every counter whose spike bit is 1 increments by 1;
  - ts_cnt increments, wrapping 2^TS_W-1 → 0.
- A counter at 2^CNT_W-1 with a spike stays saturated and sets sat_sticky.
- With count_en=0, spike_valid_i is ignored entirely.

Collisions, same cycle (priority high → low)
- reset
- clear write: zeroes all counters, ts_cnt and sat_sticky; that cycle's spike is dropped.
- CNT write to a counter: written value wins over increment for that counter only.
- spike increment.
- A STATUS W1C and a new saturation in the same cycle leave sat_sticky=1.
- A read in the same cycle as a spike returns pre-increment values.

Reset mid-transaction
- Returns to IDLE with no ack; the master must retry.

Optional Feature:
Macro SPIKE_CLEAR_ON_READ_EN.
- Defined: a CNT read zeroes the counters of that word on the read edge. The returned data is the pre-clear value. A spike landing on the same edge leaves that counter at 1 (not lost).
- Undefined: reads have no side effects.
- CTRL/STATUS reads are unaffected either way.

Decomposition:
- Package nvm_snn_pkg holds:
  - word-index constants CTRL_IDX=0, STATUS_IDX=1, CNT_BASE_IDX=2;
  - CTRL/STATUS bit positions;
  - function cnt_words(n, w).
- One natural sub-module: nvm_sat_counter (CNT_W parameter; inputs inc, load, load_val, clr; outputs value and sat_hit), instantiated N_NEURONS times via generate.

Test Plan:
1. Reset, then read CTRL/STATUS/CNT[0] → 0x0, 0x0, 0x0. Ack one cycle after stb, single-cycle pulse.
2. count_en=1; 3 pulses of spike_vec=bit0|bit9 → CNT[0]=0x00000003, CNT[1]=0x00000030, STATUS=0x00030000.
3. 17 pulses on bit5 (CNT_W=4) → CNT[0]=0x00F00000, STATUS bit0=1. Write STATUS=1 → bit0=0.
4. Write CTRL=0x2 in the same cycle as spike_valid on all bits → all CNT=0, ts_cnt=0.
5. Write CNT[0]=0xAAAAAAAA with sel=4'b0001 → CNT[0]=0x000000AA. An access to word index 60 → acked, reads 0.
6. With SPIKE_CLEAR_ON_READ_EN: counter=5, read CNT[0] → returns 5; immediate re-read → 0; read coincident with a spike → next read 1.

Source files
------------

// File: rtl/nvm_snn_pkg.sv
// Shared constants and helpers for the SNN spike counter bank:
// register word indices, register bit positions, the Wishbone FSM state
// type and small elaboration-time helper functions.
package nvm_snn_pkg;

    // Register word indices (byte address bits [2 +: AW])
    localparam int CTRL_IDX     = 0;
    localparam int STATUS_IDX   = 1;
    localparam int CNT_BASE_IDX = 2;

    // CTRL bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    // STATUS bit positions
    localparam int STATUS_SAT_BIT = 0;
    localparam int STATUS_TS_LSB  = 16;

    // Wishbone slave handshake states
    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_e;

    // Number of 32-bit words needed to pack n counters of w bits each
    function automatic int cnt_words(input int n, input int w);
        int cpw;
        cpw = 32 / w;
        return (n + cpw - 1) / cpw;
    endfunction

    // Byte lanes covering counter slot 'slot' of width w inside a 32-bit word
    function automatic logic [3:0] lane_mask(input int slot, input int w);
        logic [3:0] m;
        int         first;
        int         last;
        first = (slot * w) / 8;
        last  = ((slot + 1) * w - 1) / 8;
        for (int b = 0; b < 4; b++) begin
            m[b] = (b >= first) && (b <= last);
        end
        return m;
    endfunction

endpackage

// File: rtl/nvm_sat_counter.sv
// Single saturating spike counter.
// Priority: clr > load > inc. A clear that coincides with an increment
// leaves the counter at 1 so a spike landing on a clear-on-read edge is
// kept; a hard clear suppresses inc upstream instead.
module nvm_sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             inc,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clr,
    output logic [CNT_W-1:0] value,
    output logic             sat_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] value_r;

    // Counter register: clear, preload, or saturating increment
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            value_r <= '0;
        end else if (clr) begin
            value_r <= inc ? CNT_ONE : '0;
        end else if (load) begin
            value_r <= load_val;
        end else if (inc && (value_r != CNT_MAX)) begin
            value_r <= value_r + CNT_ONE;
        end else begin
            value_r <= value_r;
        end
    end

    assign value   = value_r;
    // Only an increment that actually applies can saturate
    assign sat_hit = inc && !clr && !load && (value_r == CNT_MAX);

endmodule

// File: rtl/nvm_spike_counter_bank.sv
// Wishbone-readable bank of saturating per-neuron spike counters.
// Host controls counting/clear via CTRL, monitors saturation and the
// timestep count via STATUS, and reads/preloads packed counters.
// Optional build macro SPIKE_CLEAR_ON_READ_EN: a CNT read zeroes the
// counters of the word read (data returned is the pre-clear value).
module nvm_spike_counter_bank
    import nvm_snn_pkg::*;
#(
    parameter int N_NEURONS = 64,
    parameter int CNT_W     = 4,
    parameter int TS_W      = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    input  logic                 spike_valid_i,
    input  logic [N_NEURONS-1:0] spike_vec_i
);

    localparam int CPW     = 32 / CNT_W;
    localparam int N_WORDS = cnt_words(N_NEURONS, CNT_W);
    localparam int AW      = $clog2(N_WORDS + 2);
    localparam int FLAT_W  = N_WORDS * 32;

    wb_state_e          state_r;
    logic               ack_r;
    logic [31:0]        dat_r;
    logic               count_en_r;
    logic               sat_sticky_r;
    logic [TS_W-1:0]    ts_cnt_r;

    logic [AW-1:0]      idx_s;
    logic               acc_s;
    logic               wr_s;
    logic               ctrl_wr_s;
    logic               clear_s;
    logic               w1c_s;
    logic               inc_en_s;
    logic               sat_any_s;
    logic [N_NEURONS-1:0] sat_hit_s;
    logic [CNT_W-1:0]   cnt_val_s [N_NEURONS];
    logic [FLAT_W-1:0]  cnt_flat_s;
    logic [31:0]        rdata_s;
    logic               unused_s;

    assign idx_s     = wbs_adr_i[2 +: AW];
    // A request is only taken in IDLE, so a held strobe is acked every other cycle
    assign acc_s     = (state_r == WB_IDLE) && wbs_cyc_i && wbs_stb_i;
    assign wr_s      = acc_s && wbs_we_i;
    assign ctrl_wr_s = wr_s && (idx_s == AW'(CTRL_IDX)) && wbs_sel_i[0];
    assign clear_s   = ctrl_wr_s && wbs_dat_i[CTRL_CLR_BIT];
    assign w1c_s     = wr_s && (idx_s == AW'(STATUS_IDX)) && wbs_sel_i[0]
                       && wbs_dat_i[STATUS_SAT_BIT];
    // A clear write drops the spike of the same cycle
    assign inc_en_s  = spike_valid_i && count_en_r && !clear_s;
    assign sat_any_s = |sat_hit_s;
    assign unused_s  = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i};

    for (genvar n = 0; n < N_NEURONS; n++) begin : g_cnt
        localparam int         WORD  = n / CPW;
        localparam int         SLOT  = n % CPW;
        localparam logic [3:0] LMASK = lane_mask(SLOT, CNT_W);

        logic hit_s;
        logic load_s;
        logic clr_s;

        assign hit_s  = (idx_s == AW'(CNT_BASE_IDX + WORD));
        assign load_s = wr_s && hit_s && ((wbs_sel_i & LMASK) == LMASK);
`ifdef SPIKE_CLEAR_ON_READ_EN
        assign clr_s  = clear_s || (acc_s && !wbs_we_i && hit_s);
`else
        assign clr_s  = clear_s;
`endif

        nvm_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .wb_clk_i (wb_clk_i),
            .wb_rst_i (wb_rst_i),
            .inc      (inc_en_s && spike_vec_i[n]),
            .load     (load_s),
            .load_val (wbs_dat_i[SLOT*CNT_W +: CNT_W]),
            .clr      (clr_s),
            .value    (cnt_val_s[n]),
            .sat_hit  (sat_hit_s[n])
        );
    end

    // Pack counters into words; bits past the last neuron stay zero
    always_comb begin
        cnt_flat_s = '0;
        for (int n = 0; n < N_NEURONS; n++) begin
            cnt_flat_s[n*CNT_W +: CNT_W] = cnt_val_s[n];
        end
    end

    // Read data mux over the register map (pre-update values)
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (idx_s == AW'(CTRL_IDX)) begin
            rdata_s[CTRL_EN_BIT] = count_en_r;
        end else if (idx_s == AW'(STATUS_IDX)) begin
            rdata_s[STATUS_SAT_BIT]        = sat_sticky_r;
            rdata_s[STATUS_TS_LSB +: TS_W] = ts_cnt_r;
        end else if ((int'(idx_s) >= CNT_BASE_IDX) && (int'(idx_s) < CNT_BASE_IDX + N_WORDS)) begin
            rdata_s = cnt_flat_s[(int'(idx_s) - CNT_BASE_IDX)*32 +: 32];
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Wishbone handshake FSM with registered ack and read data
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= WB_IDLE;
            ack_r   <= 1'b0;
            dat_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                WB_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        state_r <= WB_ACK;
                        ack_r   <= 1'b1;
                        dat_r   <= wbs_we_i ? 32'h0000_0000 : rdata_s;
                    end else begin
                        state_r <= WB_IDLE;
                        ack_r   <= 1'b0;
                        dat_r   <= 32'h0000_0000;
                    end
                end
                WB_ACK: begin
                    state_r <= WB_IDLE;
                    ack_r   <= 1'b0;
                    dat_r   <= 32'h0000_0000;
                end
                default: begin
                    state_r <= WB_IDLE;
                    ack_r   <= 1'b0;
                    dat_r   <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Control/status registers: count enable, saturation sticky, timestep count
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count_en_r   <= 1'b0;
            sat_sticky_r <= 1'b0;
            ts_cnt_r     <= '0;
        end else begin
            if (ctrl_wr_s) begin
                count_en_r <= wbs_dat_i[CTRL_EN_BIT];
            end else begin
                count_en_r <= count_en_r;
            end

            if (clear_s) begin
                ts_cnt_r <= '0;
            end else if (inc_en_s) begin
                ts_cnt_r <= ts_cnt_r + TS_W'(1);
            end else begin
                ts_cnt_r <= ts_cnt_r;
            end

            // New saturation beats a same-cycle write-1-to-clear
            if (clear_s) begin
                sat_sticky_r <= 1'b0;
            end else if (sat_any_s) begin
                sat_sticky_r <= 1'b1;
            end else if (w1c_s) begin
                sat_sticky_r <= 1'b0;
            end else begin
                sat_sticky_r <= sat_sticky_r;
            end
        end
    end

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;

endmodule
